ne_thresh_detect: RTL
=====================

NE_THRESH_DETECT -- requirements
Module: ne_thresh_detect

Interface
REQ-001 SHALL have parameter DATA_W, default 40, the signed width of the NE value consumed.
REQ-002 SHALL have parameter CNT_W, default 4, the width of the persistence counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, active-low enable; when high, all state is frozen.
REQ-006 SHALL have port din, input, DATA_W signed, the NE window sum from the upstream NE datapath.
REQ-007 SHALL have port din_valid, input, 1, a one-cycle strobe marking din as a new window value.
REQ-008 SHALL have port thresh, input, DATA_W signed, the detection threshold, sampled with each valid din.
REQ-009 SHALL have port on_cnt, input, CNT_W, the number of consecutive above-threshold windows needed to assert detect.
REQ-010 SHALL have port off_cnt, input, CNT_W, the number of consecutive below-threshold windows needed to release detect.
REQ-011 SHALL have port detect, output, 1, the registered event-active flag.
REQ-012 SHALL have port event_pulse, output, 1, a one-cycle pulse on the detect rising transition.
REQ-013 SHALL have port dout_valid, output, 1, a one-cycle strobe, one cycle after each accepted din_valid.
REQ-014 SHALL have port peak, output, DATA_W signed, the maximum din seen during the current or last event.

Function
REQ-015 SHALL accept a sample only when en==0 and din_valid==1; all other cycles leave the state unchanged.
REQ-016 SHALL classify a sample as "above" only if din > thresh (signed, strict); din == thresh counts as below.
REQ-017 SHALL implement the FSM states IDLE, ARMING, ACTIVE and RELEASING.
REQ-018 IDLE: above -> ARMING with cnt=1; below -> remain in IDLE.
REQ-019 ARMING: above -> cnt+1; when cnt reaches on_cnt -> ACTIVE; below -> IDLE with cnt=0.
REQ-020 ACTIVE: below -> RELEASING with cnt=1; above -> remain in ACTIVE.
REQ-021 RELEASING: below -> cnt+1; when cnt reaches off_cnt -> IDLE; above -> ACTIVE with cnt=0.
REQ-022 SHALL treat on_cnt==0 or off_cnt==0 as 1, so the transition happens on the first qualifying sample.
REQ-023 SHALL saturate cnt at its all-ones value and never wrap.
REQ-024 detect SHALL be 1 exactly in ACTIVE and RELEASING, and SHALL update one cycle after the accepted sample.
REQ-025 event_pulse SHALL assert for one cycle together with dout_valid on each ARMING->ACTIVE or IDLE->ACTIVE entry.
REQ-026 A change to thresh, on_cnt or off_cnt SHALL take effect at the next accepted sample, with no reset of the FSM.
REQ-027 If din_valid arrives while en==1, SHALL drop the sample with no output strobe.

Reset
REQ-028 On rst==0, regardless of clk, SHALL force state=IDLE, cnt=0, detect=0, event_pulse=0, dout_valid=0 and peak=0.
REQ-029 A reset asserted mid-event SHALL terminate the event; no event_pulse SHALL follow the reset release.

Configuration
REQ-030 Macro NE_PEAK_CAPTURE_EN SHALL control peak capture.
REQ-031 With NE_PEAK_CAPTURE_EN defined:
- peak SHALL load din when an event starts (the sample that causes entry to ACTIVE).
- peak SHALL then update to max(peak, din) on every accepted sample in ACTIVE or RELEASING.
- peak SHALL hold its value in IDLE.
REQ-032 Without NE_PEAK_CAPTURE_EN, the peak port SHALL remain present and tied to 0, with no peak register synthesized.

Structure
REQ-033 The shared package SHALL hold the FSM state enum, the default widths (DATA_W=40, CNT_W=4) and the min-count-of-1 helper constant.
REQ-034 SHALL contain one sub-module, ne_persist_cnt: the saturating counter with its load-1, clear and increment controls.

Verification
REQ-035 thresh=100, on_cnt=3, din sequence 101,150,200 -> detect=1 and event_pulse=1 one cycle after the third valid.
REQ-036 thresh=100, on_cnt=3, din 150,150,100,150 -> detect stays 0 (100 is not above); FSM is in ARMING after the last sample.
REQ-037 In ACTIVE, off_cnt=2, din 50,300,50,50 -> detect stays 1 through 300; it falls one cycle after the fourth sample.
REQ-038 on_cnt=0, single din=101 with thresh=100 -> detect=1 after one sample; off_cnt=15 with 20 below samples -> counter saturates and release happens at 15.
REQ-039 rst pulsed low in ACTIVE between clock edges -> detect, peak and dout_valid go to 0 immediately; a following above sample moves the FSM to ARMING, not ACTIVE.
REQ-040 NE_PEAK_CAPTURE_EN defined, event samples 120,-5,400,90 (thresh=100, on_cnt=1) -> peak=120, then 120, 400, 400; negative values compare correctly as signed.

Source files
------------

// File: rtl/ne_thresh_detect_pkg.sv
// Shared types and constants for the NE threshold detector: FSM state encoding,
// default widths and the minimum persistence count.
package ne_thresh_detect_pkg;

    localparam int DEF_DATA_W = 40;
    localparam int DEF_CNT_W  = 4;

    // A programmed count of zero behaves as this value.
    localparam int MIN_CNT = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_RELEASING = 2'd3
    } ne_state_t;

endpackage

// File: rtl/ne_persist_cnt.sv
// Saturating persistence counter with clear, load-one and increment controls.
// cnt_inc presents the saturated next value so the FSM can compare ahead.
module ne_persist_cnt
    import ne_thresh_detect_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_one,
    input  logic             incr,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_inc
);

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= CNT_W'(1);
        end else if (incr) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/ne_thresh_detect.sv
// NE threshold detector with on/off persistence hysteresis.
// Optional peak capture is enabled by defining NE_PEAK_CAPTURE_EN.
module ne_thresh_detect
    import ne_thresh_detect_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] thresh,
    input  logic [CNT_W-1:0]         on_cnt,
    input  logic [CNT_W-1:0]         off_cnt,
    output logic                     detect,
    output logic                     event_pulse,
    output logic                     dout_valid,
    output logic signed [DATA_W-1:0] peak
);

    ne_state_t        state, state_nxt;
    logic             accept, above, event_start;
    logic             cnt_clear, cnt_load_one, cnt_incr;
    logic [CNT_W-1:0] cnt, cnt_inc, on_eff, off_eff;

    assign accept  = ~en & din_valid;
    assign above   = din > thresh;
    assign on_eff  = (on_cnt == '0)  ? CNT_W'(MIN_CNT) : on_cnt;
    assign off_eff = (off_cnt == '0) ? CNT_W'(MIN_CNT) : off_cnt;

    ne_persist_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .incr     (cnt_incr),
        .cnt      (cnt),
        .cnt_inc  (cnt_inc)
    );

    // Comparing with >= lets a lowered on/off count take effect on the next sample.
    always_comb begin
        state_nxt    = state;
        cnt_clear    = 1'b0;
        cnt_load_one = 1'b0;
        cnt_incr     = 1'b0;
        event_start  = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (above) begin
                        if (on_eff == CNT_W'(MIN_CNT)) begin
                            state_nxt   = ST_ACTIVE;
                            cnt_clear   = 1'b1;
                            event_start = 1'b1;
                        end else begin
                            state_nxt    = ST_ARMING;
                            cnt_load_one = 1'b1;
                        end
                    end
                end
                ST_ARMING: begin
                    if (!above) begin
                        state_nxt = ST_IDLE;
                        cnt_clear = 1'b1;
                    end else if (cnt_inc >= on_eff) begin
                        state_nxt   = ST_ACTIVE;
                        cnt_clear   = 1'b1;
                        event_start = 1'b1;
                    end else begin
                        cnt_incr = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!above) begin
                        if (off_eff == CNT_W'(MIN_CNT)) begin
                            state_nxt = ST_IDLE;
                            cnt_clear = 1'b1;
                        end else begin
                            state_nxt    = ST_RELEASING;
                            cnt_load_one = 1'b1;
                        end
                    end
                end
                ST_RELEASING: begin
                    if (above) begin
                        state_nxt = ST_ACTIVE;
                        cnt_clear = 1'b1;
                    end else if (cnt_inc >= off_eff) begin
                        state_nxt = ST_IDLE;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_incr = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Strobes are rebuilt every cycle so they never stick while en freezes the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            detect      <= 1'b0;
            event_pulse <= 1'b0;
            dout_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            detect      <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_RELEASING);
            event_pulse <= event_start;
            dout_valid  <= accept;
        end
    end

`ifdef NE_PEAK_CAPTURE_EN
    logic signed [DATA_W-1:0] peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else if (accept) begin
            if (event_start) begin
                peak_q <= din;
            end else if (((state == ST_ACTIVE) || (state == ST_RELEASING)) && (din > peak_q)) begin
                peak_q <= din;
            end
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule
